// File: rtl/gear_adder_ecu_pkg.sv
// Shared GeAr segmentation helpers: segment count, segment bounds and FSM encoding.
// The combinational GeAr adder uses the same helpers so both agree on segment layout.
`define GEAR_MAX(a, b) (((a) > (b)) ? (a) : (b))

package gear_pkg;

    // Number of segments for a BITS-wide adder with R result bits and P overlap bits.
    function automatic int gear_k(input int bits, input int r, input int p);
        int l;
        l = r + p;
        return (bits > l) ? 1 + (bits - l + r - 1) / r : 1;
    endfunction

    function automatic int gear_cw(input int k);
        return (k > 1) ? $clog2(k) : 1;
    endfunction

    function automatic int seg_lo(input int i, input int r, input int p);
        return (i == 0) ? 0 : p + i * r;
    endfunction

    function automatic int seg_hi(input int i, input int r, input int p, input int bits);
        int h;
        h = (i == 0) ? r + p : p + (i + 1) * r;
        return (h > bits) ? bits : h;
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        CORR = 2'd2,
        HOLD = 2'd3
    } state_t;

endpackage

// File: rtl/gear_adder_ecu_if.sv
// Operand/result handshake bundle for the error-correcting GeAr adder.
interface gear_adder_ecu_if
    import gear_pkg::*;
#(
    parameter int WIDTH_A = 16,
    parameter int WIDTH_B = 16,
    parameter int R       = 4,
    parameter int P       = 4
);
    localparam int BITS = `GEAR_MAX(WIDTH_A, WIDTH_B);
    localparam int K    = gear_k(BITS, R, P);
    localparam int CW   = gear_cw(K);

    logic               in_valid;
    logic               in_ready;
    logic [WIDTH_A-1:0] A;
    logic [WIDTH_B-1:0] B;
    logic               exact;
    logic               out_valid;
    logic               out_ready;
    logic [BITS-1:0]    OUT;
    logic               err;
    logic [CW-1:0]      corr_cycles;

    modport master (
        output in_valid, A, B, exact, out_ready,
        input  in_ready, out_valid, OUT, err, corr_cycles
    );

    modport slave (
        input  in_valid, A, B, exact, out_ready,
        output in_ready, out_valid, OUT, err, corr_cycles
    );
endinterface

// File: rtl/gear_adder_ecu_seg_add.sv
// One GeAr segment: W-bit field adder with explicit carry-in and carry-out.
module gear_seg_add #(
    parameter int W = 4
) (
    input  logic [W-1:0] a_f,
    input  logic [W-1:0] b_f,
    input  logic         cin,
    output logic [W-1:0] field,
    output logic         cout
);
    assign {cout, field} = {1'b0, a_f} + {1'b0, b_f} + {{W{1'b0}}, cin};
endmodule

// File: rtl/gear_adder_ecu.sv
// Sequential GeAr adder: one-cycle approximate sum, then optional per-cycle repair of
// the lowest mispredicted segment until the sum is exact.
module gear_adder_ecu
    import gear_pkg::*;
#(
    parameter int R       = 4,
    parameter int P       = 4,
    parameter int WIDTH_A = 16,
    parameter int WIDTH_B = 16
) (
    input logic             clk,
    input logic             rst_n,
    gear_adder_ecu_if.slave bus
);
    localparam int BITS = `GEAR_MAX(WIDTH_A, WIDTH_B);
    localparam int K    = gear_k(BITS, R, P);
    localparam int CW   = gear_cw(K);

    state_t          state_reg;
    logic [BITS-1:0] a_reg, b_reg, sum_reg;
    logic [K-1:0]    co_reg, cin_reg;
    logic            exact_reg, err_reg;
    logic [CW-1:0]   corr_reg;

    logic [BITS-1:0] ext_a, ext_b, op_a, op_b, add_sum, sum_next, fix_mask;
    logic [K-1:0]    cin_vec, seg_cout, e_vec, e_next, co_next, cin_next;
    logic [BITS-1:0] seg_mask [K];
    logic [CW-1:0]   fix_idx;
    logic            has_err, accept;

    assign ext_a  = BITS'($signed(bus.A));
    assign ext_b  = BITS'($signed(bus.B));
    assign op_a   = (state_reg == IDLE) ? ext_a : a_reg;
    assign op_b   = (state_reg == IDLE) ? ext_b : b_reg;
    assign accept = bus.in_valid && (state_reg == IDLE);

    // The carry-in actually applied to each segment is stored, so a repaired segment
    // stops flagging once its carry-in matches the true carry from below.
    generate
        for (genvar gi = 0; gi < K; gi++) begin : g_seg
            localparam int LO = seg_lo(gi, R, P);
            localparam int HI = seg_hi(gi, R, P, BITS);
            localparam int W  = HI - LO;
            localparam logic [BITS-1:0] MASK = ({BITS{1'b1}} >> (BITS - W)) << LO;

            assign seg_mask[gi] = MASK;

            if (gi == 0) begin : g_low
                assign cin_vec[gi] = 1'b0;
                assign e_vec[gi]   = 1'b0;
                assign e_next[gi]  = 1'b0;
            end else begin : g_up
                logic [P:0] pred_sum;
                assign pred_sum    = {1'b0, ext_a[gi*R +: P]} + {1'b0, ext_b[gi*R +: P]};
                assign cin_vec[gi] = (state_reg == IDLE) ? pred_sum[P] : co_reg[gi-1];
                assign e_vec[gi]   = cin_reg[gi] ^ co_reg[gi-1];
                assign e_next[gi]  = cin_next[gi] ^ co_next[gi-1];
            end

            gear_seg_add #(.W(W)) u_seg (
                .a_f   (op_a[HI-1:LO]),
                .b_f   (op_b[HI-1:LO]),
                .cin   (cin_vec[gi]),
                .field (add_sum[HI-1:LO]),
                .cout  (seg_cout[gi])
            );
        end
    endgenerate

    // Lowest-error priority encoder and the single-segment repair it selects.
    always_comb begin
        fix_idx  = '0;
        fix_mask = '0;
        co_next  = co_reg;
        cin_next = cin_reg;
        has_err  = |e_vec;
        for (int i = K - 1; i >= 0; i--) begin
            if (e_vec[i]) fix_idx = CW'(i);
        end
        if (has_err) begin
            co_next[fix_idx]  = seg_cout[fix_idx];
            cin_next[fix_idx] = cin_vec[fix_idx];
            fix_mask          = seg_mask[fix_idx];
        end
        sum_next = (sum_reg & ~fix_mask) | (add_sum & fix_mask);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            co_reg    <= '0;
            cin_reg   <= '0;
            exact_reg <= 1'b0;
            err_reg   <= 1'b0;
            corr_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: if (accept) begin
                    a_reg     <= ext_a;
                    b_reg     <= ext_b;
                    sum_reg   <= add_sum;
                    co_reg    <= seg_cout;
                    cin_reg   <= cin_vec;
                    exact_reg <= bus.exact;
                    err_reg   <= 1'b0;
                    corr_reg  <= '0;
                    state_reg <= EVAL;
                end
                EVAL: begin
                    err_reg   <= has_err;
                    state_reg <= (exact_reg && has_err) ? CORR : HOLD;
                end
                CORR: begin
                    if (has_err) begin
                        sum_reg  <= sum_next;
                        co_reg   <= co_next;
                        cin_reg  <= cin_next;
                        corr_reg <= corr_reg + 1'b1;
                        if (!(|e_next)) state_reg <= HOLD;
                    end else begin
                        state_reg <= HOLD;
                    end
                end
                HOLD: if (bus.out_ready) state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    logic unused_bits;
    assign unused_bits = cin_reg[0] ^ co_reg[K-1];

    assign bus.in_ready    = (state_reg == IDLE);
    assign bus.out_valid   = (state_reg == HOLD);
    assign bus.OUT         = sum_reg;
    assign bus.err         = err_reg;
    assign bus.corr_cycles = corr_reg;
endmodule

// File: tb/tb_gear_adder_ecu.sv
// Directed and randomised checks of gear_adder_ecu (16/16 and 8/16 operand widths).
module tb_gear_adder_ecu;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    gear_adder_ecu_if #(.WIDTH_A(16), .WIDTH_B(16)) bus16 ();
    gear_adder_ecu_if #(.WIDTH_A(8),  .WIDTH_B(16)) bus8 ();

    gear_adder_ecu #(.R(4), .P(4), .WIDTH_A(16), .WIDTH_B(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .bus(bus16.slave));
    gear_adder_ecu #(.R(4), .P(4), .WIDTH_A(8), .WIDTH_B(16)) dut8 (
        .clk(clk), .rst_n(rst_n), .bus(bus8.slave));

    logic [15:0] a_drv, b_drv;
    logic        ex_drv, rdy_drv, vld16, vld8;

    assign bus16.A         = a_drv;
    assign bus16.B         = b_drv;
    assign bus16.exact     = ex_drv;
    assign bus16.out_ready = rdy_drv;
    assign bus16.in_valid  = vld16;
    assign bus8.A          = a_drv[7:0];
    assign bus8.B          = b_drv;
    assign bus8.exact      = ex_drv;
    assign bus8.out_ready  = rdy_drv;
    assign bus8.in_valid   = vld8;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] obs_out(input bit s8);
        return s8 ? bus8.OUT : bus16.OUT;
    endfunction
    function automatic logic obs_ov(input bit s8);
        return s8 ? bus8.out_valid : bus16.out_valid;
    endfunction
    function automatic logic obs_ir(input bit s8);
        return s8 ? bus8.in_ready : bus16.in_ready;
    endfunction
    function automatic logic obs_err(input bit s8);
        return s8 ? bus8.err : bus16.err;
    endfunction
    function automatic int obs_cc(input bit s8);
        return s8 ? int'(bus8.corr_cycles) : int'(bus16.corr_cycles);
    endfunction

    // Reference GeAr approximation for R=P=4, 16 bits, written from the segment formula.
    function automatic logic [15:0] approx_model(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        logic [8:0]  s0;
        logic [4:0]  t, f;
        s0 = {1'b0, a[7:0]} + {1'b0, b[7:0]};
        r = '0;
        r[7:0] = s0[7:0];
        for (int i = 1; i <= 2; i++) begin
            t = {1'b0, a[i*4 +: 4]} + {1'b0, b[i*4 +: 4]};
            f = {1'b0, a[4+i*4 +: 4]} + {1'b0, b[4+i*4 +: 4]} + {4'b0, t[4]};
            r[4+i*4 +: 4] = f[3:0];
        end
        return r;
    endfunction

    // Called at #1 after a rising edge; returns the result still held (not retired).
    task automatic run_txn(input bit s8, input logic [15:0] a, input logic [15:0] b,
                           input bit ex, output logic [15:0] out, output logic e,
                           output int cc, output int lat);
        int w;
        w = 0;
        while (!obs_ir(s8) && w < 20) begin
            @(posedge clk); #1; w++;
        end
        check("in_ready_wait", 32'(obs_ir(s8)), 32'd1);
        a_drv = a; b_drv = b; ex_drv = ex;
        if (s8) vld8 = 1'b1; else vld16 = 1'b1;
        @(posedge clk); #1;
        vld8 = 1'b0; vld16 = 1'b0;
        lat = 1;
        while (!obs_ov(s8) && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        if (!obs_ov(s8)) check("out_valid_timeout", 32'(obs_ov(s8)), 32'd1);
        out = obs_out(s8);
        e   = obs_err(s8);
        cc  = obs_cc(s8);
        $display("txn dut%0d a=%h b=%h exact=%0d -> out=%h err=%0d corr=%0d lat=%0d",
                 s8 ? 8 : 16, a, b, ex, out, e, cc, lat);
    endtask

    task automatic retire();
        rdy_drv = 1'b1;
        @(posedge clk); #1;
        rdy_drv = 1'b0;
    endtask

    typedef struct {
        bit          s8;
        logic [15:0] a;
        logic [15:0] b;
        bit          ex;
        logic [15:0] out;
        bit          err;
        int          cc;
    } vec_t;

    vec_t vecs [9];

    initial begin
        logic [15:0] out, ea, ex_sum;
        logic        e;
        int          cc, lat;

        vecs[0] = '{0, 16'h1234, 16'h0101, 1, 16'h1335, 0, 0};
        vecs[1] = '{0, 16'h00FF, 16'h0001, 0, 16'h0000, 1, 0};
        vecs[2] = '{0, 16'h00FF, 16'h0001, 1, 16'h0100, 1, 1};
        vecs[3] = '{0, 16'h0FFF, 16'h0001, 1, 16'h1000, 1, 2};
        vecs[4] = '{0, 16'h0FFF, 16'h0001, 0, 16'h0F00, 1, 0};
        vecs[5] = '{1, 16'h00FF, 16'h0001, 1, 16'h0000, 1, 2};
        vecs[6] = '{1, 16'h00FF, 16'h0001, 0, 16'hFF00, 1, 0};
        vecs[7] = '{0, 16'h0F00, 16'h0100, 1, 16'h1000, 0, 0};
        vecs[8] = '{0, 16'hFFFF, 16'h0001, 1, 16'h0000, 1, 2};

        a_drv = '0; b_drv = '0; ex_drv = 1'b0; rdy_drv = 1'b0; vld16 = 1'b0; vld8 = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #2;
        check("rst_in_ready",  32'(bus16.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus16.out_valid), 32'd0);
        check("rst_out",       32'(bus16.OUT), 32'd0);
        check("rst_err",       32'(bus16.err), 32'd0);
        check("rst_corr",      32'(bus16.corr_cycles), 32'd0);
        check("rst_out_valid8", 32'(bus8.out_valid), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            run_txn(vecs[i].s8, vecs[i].a, vecs[i].b, vecs[i].ex, out, e, cc, lat);
            check($sformatf("vec%0d_out", i),  32'(out), 32'(vecs[i].out));
            check($sformatf("vec%0d_err", i),  32'(e),   32'(vecs[i].err));
            check($sformatf("vec%0d_corr", i), 32'(cc),  32'(vecs[i].cc));
            check($sformatf("vec%0d_lat", i),  32'(lat), 32'(2 + vecs[i].cc));
            retire();
            check($sformatf("vec%0d_retired", i), 32'(obs_ov(vecs[i].s8)), 32'd0);
        end

        // Back-pressure: result stays put and operand pulses are ignored.
        run_txn(0, 16'h0FFF, 16'h0001, 1, out, e, cc, lat);
        for (int i = 0; i < 5; i++) begin
            a_drv = 16'h1111; b_drv = 16'h2222; vld16 = 1'b1;
            @(posedge clk); #1;
            check("hold_out",       32'(bus16.OUT), 32'h1000);
            check("hold_err",       32'(bus16.err), 32'd1);
            check("hold_corr",      32'(bus16.corr_cycles), 32'd2);
            check("hold_out_valid", 32'(bus16.out_valid), 32'd1);
            check("hold_in_ready",  32'(bus16.in_ready), 32'd0);
        end
        rdy_drv = 1'b1;
        @(posedge clk); #1;
        rdy_drv = 1'b0;
        check("retire_in_ready",  32'(bus16.in_ready), 32'd1);
        check("retire_out_valid", 32'(bus16.out_valid), 32'd0);
        vld16 = 1'b0;

        // Reset while correcting: EVAL after accept, CORR one edge later.
        a_drv = 16'h0FFF; b_drv = 16'h0001; ex_drv = 1'b1; vld16 = 1'b1;
        @(posedge clk); #1;
        vld16 = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready",  32'(bus16.in_ready), 32'd1);
        check("midrst_out_valid", 32'(bus16.out_valid), 32'd0);
        check("midrst_out",       32'(bus16.OUT), 32'd0);
        check("midrst_err",       32'(bus16.err), 32'd0);
        check("midrst_corr",      32'(bus16.corr_cycles), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        run_txn(0, 16'h0FFF, 16'h0001, 1, out, e, cc, lat);
        check("postrst_out",  32'(out), 32'h1000);
        check("postrst_corr", 32'(cc),  32'd2);
        check("postrst_lat",  32'(lat), 32'd4);
        retire();

        for (int i = 0; i < 1000; i++) begin
            logic [15:0] ra, rb;
            bit          rex;
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            rex = bit'(i & 1);
            ea     = approx_model(ra, rb);
            ex_sum = ra + rb;
            run_txn(0, ra, rb, rex, out, e, cc, lat);
            check($sformatf("rnd%0d_out", i), 32'(out), 32'(rex ? ex_sum : ea));
            check($sformatf("rnd%0d_err", i), 32'(e), 32'(ea != ex_sum));
            if (rex) check($sformatf("rnd%0d_corr_bound", i), 32'(cc <= 2), 32'd1);
            else     check($sformatf("rnd%0d_corr", i), 32'(cc), 32'd0);
            check($sformatf("rnd%0d_lat", i), 32'(lat), 32'(2 + cc));
            retire();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
